dose_scheduler: RTL and testbench

Parametrised multi-compartment dose scheduler that sits between the time-of-day trigger logic and the compartment motor drivers. It holds a per-compartment slot mask and remaining-pill count, latches dose requests from slot pulses and manual overrides, and serves them one at a time with round-robin arbitration. Each dose is a fixed-length toggling motor burst followed by a settle gap. It replaces the fixed two-compartment, three-slot dispense path with a configurable N-channel one that adds pill counting and request coalescing.

---
 rtl/dose_sched_pkg.sv | 21 ++
 rtl/dose_pulse_gen.sv | 76 +++++++
 rtl/dose_scheduler.sv | 139 +++++++++++++
 tb/tb_dose_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dose_sched_pkg.sv
// Shared types, default parameters and width helper for the dose scheduler.
package dose_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_NUM_SLOTS    = 3;
  localparam int DEF_CNT_W        = 6;
  localparam int DEF_PULSE_CYCLES = 10;
  localparam int DEF_GAP_CYCLES   = 4;

  // A single-channel build still needs a one-bit channel index.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dose_pulse_gen.sv
// Burst timer: toggling motor drive for PULSE_CYCLES, then a GAP_CYCLES settle.
module dose_pulse_gen
  import dose_sched_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  output logic motor_en,
  output logic in_pulse,
  output logic in_gap,
  output logic pulse_last,
  output logic done
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  sched_state_t  state, state_nx;
  logic [TW-1:0] tick, tick_nx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      tick  <= '0;
    end else begin
      state <= state_nx;
      tick  <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = PULSE;
          tick_nx  = '0;
        end
      end
      PULSE: begin
        if (tick == TW'(PULSE_CYCLES - 1)) begin
          state_nx = GAP;
          tick_nx  = '0;
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      GAP: begin
        if (tick == TW'(GAP_CYCLES - 1)) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        tick_nx  = '0;
      end
    endcase
  end

  // Drive is high on even ticks so every burst starts with the motor on.
  always_comb begin
    in_pulse   = (state == PULSE);
    in_gap     = (state == GAP);
    motor_en   = in_pulse && !tick[0];
    pulse_last = in_pulse && (tick == TW'(PULSE_CYCLES - 1));
    done       = in_gap && (tick == '0);
  end

endmodule

// File: rtl/dose_scheduler.sv
// N-channel dose scheduler: per-channel mask/count/pending, request coalescing, round-robin service.
module dose_scheduler
  import dose_sched_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int CH_W         = ch_width(NUM_CH)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_SLOTS-1:0] slot_p,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [NUM_SLOTS-1:0] cfg_mask,
  input  logic [CNT_W-1:0]     cfg_count,
  input  logic                 ovr_p,
  input  logic [CH_W-1:0]      ovr_ch,
  output logic [NUM_CH-1:0]    motor,
  output logic                 busy,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    empty,
  output logic                 done_p,
  output logic [CH_W-1:0]      done_ch
);

  logic [NUM_SLOTS-1:0] mask  [NUM_CH];
  logic [CNT_W-1:0]     count [NUM_CH];
  logic [NUM_CH-1:0]    pending_q;
  logic [CH_W-1:0]      grant, last_served, done_ch_q;
  logic                 cfg_hit;
  logic [NUM_CH-1:0]    cfg_sel, req;
  logic                 arb_found;
  logic [CH_W-1:0]      arb_ch;
  logic                 start, motor_en, in_pulse, in_gap, pulse_last, gen_done;

  dose_pulse_gen #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_pulse_gen (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .motor_en   (motor_en),
    .in_pulse   (in_pulse),
    .in_gap     (in_gap),
    .pulse_last (pulse_last),
    .done       (gen_done)
  );

  // Decoding against each channel index makes out-of-range addresses match nothing.
  always_comb begin
    cfg_sel = '0;
    req     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cfg_sel[ch] = cfg_we && (cfg_ch == CH_W'(ch));
      req[ch]     = (count[ch] != '0) &&
                    ((|(slot_p & mask[ch])) || (ovr_p && (ovr_ch == CH_W'(ch))));
    end
  end

  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_ch    = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_served) + i) % NUM_CH;
      if (!arb_found && pending_q[CH_W'(idx)]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'(idx);
      end
    end
  end

  assign start = arb_found && !in_pulse && !in_gap;

  // A config write always wins; end-of-burst clearing beats a same-edge request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mask[ch]  <= '0;
        count[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (cfg_sel[ch]) begin
          mask[ch]      <= cfg_mask;
          count[ch]     <= cfg_count;
          pending_q[ch] <= 1'b0;
        end else if (pulse_last && !cfg_hit && (grant == CH_W'(ch))) begin
          pending_q[ch] <= 1'b0;
          if (count[ch] != '0) count[ch] <= count[ch] - CNT_W'(1);
        end else if (req[ch]) begin
          pending_q[ch] <= 1'b1;
        end
      end
    end
  end

  // cfg_hit remembers a reconfiguration of the channel being dispensed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant       <= '0;
      last_served <= CH_W'(NUM_CH - 1);
      done_ch_q   <= '0;
      cfg_hit     <= 1'b0;
    end else begin
      if (start) begin
        grant   <= arb_ch;
        cfg_hit <= cfg_we && (cfg_ch == arb_ch);
      end else if (in_pulse && cfg_we && (cfg_ch == grant)) begin
        cfg_hit <= 1'b1;
      end
      if (pulse_last) begin
        last_served <= grant;
        done_ch_q   <= grant;
      end
    end
  end

  always_comb begin
    motor = '0;
    empty = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      motor[ch] = motor_en && (grant == CH_W'(ch));
      empty[ch] = (count[ch] == '0);
    end
  end

  assign busy    = in_pulse || in_gap;
  assign pending = pending_q;
  assign done_p  = gen_done;
  assign done_ch = done_ch_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Randomized bench for dose_scheduler against a dose-timeline reference model.
module tb_dose_scheduler;

  localparam int NUM_CH       = 2;
  localparam int NUM_SLOTS    = 3;
  localparam int CNT_W        = 6;
  localparam int PULSE_CYCLES = 10;
  localparam int GAP_CYCLES   = 4;
  localparam int CH_W         = 1;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic [NUM_SLOTS-1:0] slot_p;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [NUM_SLOTS-1:0] cfg_mask;
  logic [CNT_W-1:0]     cfg_count;
  logic                 ovr_p;
  logic [CH_W-1:0]      ovr_ch;
  logic [NUM_CH-1:0]    motor;
  logic                 busy;
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    empty;
  logic                 done_p;
  logic [CH_W-1:0]      done_ch;

  int error_count = 0;
  int check_count = 0;
  int cycle = 0;

  // Reference model: each dose is a timeline position 0..PULSE+GAP-1, -1 when idle.
  int                   m_count [NUM_CH];
  bit [NUM_SLOTS-1:0]   m_mask  [NUM_CH];
  bit                   m_pend  [NUM_CH];
  int                   m_cur, m_t, m_last, m_done_ch;
  bit                   m_hit;

  dose_scheduler #(
    .NUM_CH       (NUM_CH),
    .NUM_SLOTS    (NUM_SLOTS),
    .CNT_W        (CNT_W),
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .slot_p    (slot_p),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mask  (cfg_mask),
    .cfg_count (cfg_count),
    .ovr_p     (ovr_p),
    .ovr_ch    (ovr_ch),
    .motor     (motor),
    .busy      (busy),
    .pending   (pending),
    .empty     (empty),
    .done_p    (done_p),
    .done_ch   (done_ch)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_count[ch] = 0;
      m_mask[ch]  = '0;
      m_pend[ch]  = 1'b0;
    end
    m_cur = 0; m_t = -1; m_last = NUM_CH - 1; m_done_ch = 0; m_hit = 1'b0;
  endfunction

  function automatic void model_step();
    bit req [NUM_CH];
    bit cfg_on [NUM_CH];
    bit end_burst, hit_old, found;
    int served, idx;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cfg_on[ch] = cfg_we && (int'(cfg_ch) == ch);
      req[ch] = (m_count[ch] != 0) &&
                (((slot_p & m_mask[ch]) != '0) || (ovr_p && int'(ovr_ch) == ch));
    end
    end_burst = (m_t == PULSE_CYCLES - 1);
    hit_old   = m_hit;
    served    = m_cur;
    if (m_t < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (m_last + k) % NUM_CH;
        if (!found && m_pend[idx]) begin
          found = 1'b1; m_cur = idx; m_t = 0; m_hit = cfg_on[idx];
        end
      end
    end else begin
      if (m_t < PULSE_CYCLES && cfg_on[m_cur]) m_hit = 1'b1;
      if (end_burst) begin m_last = m_cur; m_done_ch = m_cur; end
      m_t = (m_t == PULSE_CYCLES + GAP_CYCLES - 1) ? -1 : m_t + 1;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (cfg_on[ch]) begin
        m_mask[ch] = cfg_mask; m_count[ch] = int'(cfg_count); m_pend[ch] = 1'b0;
      end else if (end_burst && !hit_old && served == ch) begin
        m_pend[ch] = 1'b0;
        if (m_count[ch] > 0) m_count[ch] = m_count[ch] - 1;
      end else if (req[ch]) begin
        m_pend[ch] = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_motor, e_pend, e_empty;
    e_motor = '0; e_pend = '0; e_empty = '0;
    if (m_t >= 0 && m_t < PULSE_CYCLES && (m_t % 2) == 0) e_motor[m_cur] = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_pend[ch]  = m_pend[ch];
      e_empty[ch] = (m_count[ch] == 0);
    end
    checkOutput("motor",   32'(motor),   32'(e_motor));
    checkOutput("busy",    32'(busy),    32'(m_t >= 0));
    checkOutput("pending", 32'(pending), 32'(e_pend));
    checkOutput("empty",   32'(empty),   32'(e_empty));
    checkOutput("done_p",  32'(done_p),  32'(m_t == PULSE_CYCLES));
    checkOutput("done_ch", 32'(done_ch), 32'(m_done_ch));
  endtask

  task automatic applyStimulus(input logic [NUM_SLOTS-1:0] s, input logic ov, input logic [CH_W-1:0] oc,
                               input logic we, input logic [CH_W-1:0] wc,
                               input logic [NUM_SLOTS-1:0] wm, input logic [CNT_W-1:0] wn);
    slot_p = s; ovr_p = ov; ovr_ch = oc;
    cfg_we = we; cfg_ch = wc; cfg_mask = wm; cfg_count = wn;
    model_step();
    @(posedge clock);
    @(negedge clock);
    cycle++;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_async_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    resetn = 1'b1;
  endtask

  initial begin
    bit did_reset;
    logic [NUM_SLOTS-1:0] rs;
    did_reset = 1'b0;
    resetn = 1'b0;
    slot_p = '0; ovr_p = 1'b0; ovr_ch = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mask = '0; cfg_count = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    compare_all();
    resetn = 1'b1;

    $display("[TB] two-channel configured service");
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0, 3'b001, 6'd2);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b1, 3'b011, 6'd5);
    applyStimulus(3'b001, 1'b0, '0, 1'b0, '0, '0, '0);
    idle_cycles(35);

    $display("[TB] last pill then dropped request");
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0, 3'b001, 6'd1);
    applyStimulus(3'b001, 1'b0, '0, 1'b0, '0, '0, '0);
    idle_cycles(20);
    applyStimulus(3'b001, 1'b0, '0, 1'b0, '0, '0, '0);
    idle_cycles(5);

    $display("[TB] coalescing during a burst");
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b0, 3'b001, 6'd4);
    applyStimulus(3'b001, 1'b0, '0, 1'b0, '0, '0, '0);
    applyStimulus('0, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(3'b001, 1'b0, '0, 1'b0, '0, '0, '0);
    idle_cycles(35);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      if (!did_reset && n > 1500 && m_t == 5) begin
        did_reset = 1'b1;
        do_async_reset();
      end
      rs = '0;
      for (int s = 0; s < NUM_SLOTS; s++) rs[s] = ($urandom_range(0, 19) == 0);
      applyStimulus(rs,
                    $urandom_range(0, 14) == 0, CH_W'($urandom_range(0, NUM_CH - 1)),
                    $urandom_range(0, 24) == 0, CH_W'($urandom_range(0, NUM_CH - 1)),
                    NUM_SLOTS'($urandom), CNT_W'($urandom_range(0, 7)));
    end
    if (!did_reset) begin
      $display("[TB] FAIL mid_burst_reset cycle=%0d observed=0 expected=1", cycle);
      error_count++;
      check_count++;
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
